// File: rtl/uart_digest_tx_ctrl_pkg.sv
// Shared constants for the digest-to-UART byte streamer: line terminator bytes
// and the default message length.
package uart_pkg;

  localparam int DEFAULT_NUM_BYTES = 32;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_digest_tx_ctrl.sv
// Streams a latched digest word to a UART transmitter one byte at a time, MSB byte first.
// Optional macro UART_TX_CRLF_EN appends a CR/LF terminator after the last data byte.
module uart_digest_tx_ctrl
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int DATA_W    = 8 * NUM_BYTES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start_in,
  input  logic [DATA_W-1:0] Digest_in,
  output logic              Busy_out,
  output logic              Done_out,
  output logic              Tx_DV_out,
  output logic [7:0]        Tx_Byte_out,
  input  logic              Tx_Active_in,
  input  logic              Tx_Done_in
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_NEXT      = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  byte_cnt;
  logic              done_q;
  logic              done_rise;
  logic              tx_ready;
  logic              last_data;

  assign done_rise = Tx_Done_in & ~done_q;
  assign tx_ready  = ~Tx_Active_in & ~Tx_Done_in;
  assign last_data = (byte_cnt == LAST_IDX);

`ifdef UART_TX_CRLF_EN
  // tail: 0 = data bytes, 1 = CR pending/in flight, 2 = LF pending/in flight
  logic [1:0] tail;

  function automatic logic [7:0] sel_byte(input logic [1:0] t, input logic [7:0] data_byte);
    case (t)
      2'd1:    sel_byte = ASCII_CR;
      2'd2:    sel_byte = ASCII_LF;
      default: sel_byte = data_byte;
    endcase
  endfunction

  assign Tx_Byte_out = sel_byte(tail, shift_reg[DATA_W-1 -: 8]);
`else
  assign Tx_Byte_out = shift_reg[DATA_W-1 -: 8];
`endif

  assign Busy_out  = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_NEXT);
  assign Done_out  = (state == S_FINISH);
  assign Tx_DV_out = (state == S_ISSUE) && tx_ready;

  always_ff @(posedge CLK) begin
    if (RST) done_q <= 1'b0;
    else     done_q <= Tx_Done_in;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
`ifdef UART_TX_CRLF_EN
      tail      <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start_in) begin
            shift_reg <= Digest_in;
            byte_cnt  <= '0;
`ifdef UART_TX_CRLF_EN
            tail      <= 2'd0;
`endif
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tx_ready) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done_rise) state <= S_NEXT;
        end
        S_NEXT: begin
`ifdef UART_TX_CRLF_EN
          case (tail)
            2'd0: begin
              shift_reg <= shift_reg << 8;
              byte_cnt  <= byte_cnt + 1'b1;
              if (last_data) tail <= 2'd1;
              state     <= S_ISSUE;
            end
            2'd1: begin
              tail  <= 2'd2;
              state <= S_ISSUE;
            end
            default: state <= S_FINISH;
          endcase
`else
          shift_reg <= shift_reg << 8;
          byte_cnt  <= byte_cnt + 1'b1;
          state     <= last_data ? S_FINISH : S_ISSUE;
`endif
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_digest_tx_ctrl.sv
// Directed bench: two controllers (32-byte and 1-byte) each driving a behavioural
// UART transmitter with CLKS_PER_BIT=4; channel 0 also has a serial decoder.
module tb_uart_digest_tx_ctrl;
  import uart_pkg::*;

`ifdef UART_TX_CRLF_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif

  localparam logic [255:0] DIG_PAT = 256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;
  localparam logic [255:0] DIG_INC = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start0 = 1'b0, start1 = 1'b0;
  logic [255:0] digest0 = '0;
  logic [7:0]   digest1 = '0;
  logic         busy0, done0, dv0, busy1, done1, dv1;
  logic [7:0]   byte0, byte1;

  logic [1:0]   tx_active = 2'b00;
  logic [1:0]   tx_done   = 2'b00;
  logic [1:0]   ser       = 2'b11;
  int           cnt   [2] = '{0, 0};
  int           dleft [2] = '{0, 0};
  logic [9:0]   frame [2] = '{10'h0, 10'h0};
  int           done_len  = 1;

  int           n_chk = 0, n_bad = 0, viol = 0;
  int           done_cnt0 = 0, done_cnt1 = 0;
  logic [7:0]   q_dv0[$], q_dv1[$], q_rx0[$];

  uart_digest_tx_ctrl dut (
    .CLK(clk), .RST(rst), .Start_in(start0), .Digest_in(digest0),
    .Busy_out(busy0), .Done_out(done0), .Tx_DV_out(dv0), .Tx_Byte_out(byte0),
    .Tx_Active_in(tx_active[0]), .Tx_Done_in(tx_done[0])
  );

  uart_digest_tx_ctrl #(.NUM_BYTES(1), .DATA_W(8)) dut1 (
    .CLK(clk), .RST(rst), .Start_in(start1), .Digest_in(digest1),
    .Busy_out(busy1), .Done_out(done1), .Tx_DV_out(dv1), .Tx_Byte_out(byte1),
    .Tx_Active_in(tx_active[1]), .Tx_Done_in(tx_done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: start bit, 8 data bits LSB first, stop bit, 4 clocks each,
  // then Tx_Done held for done_len cycles.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (tx_active[c]) begin
        if (cnt[c] == 39) begin
          tx_active[c] <= 1'b0;
          tx_done[c]   <= 1'b1;
          dleft[c]     <= done_len - 1;
          ser[c]       <= 1'b1;
        end else begin
          cnt[c] <= cnt[c] + 1;
          ser[c] <= frame[c][(cnt[c] + 1) / 4];
        end
      end else if (tx_done[c]) begin
        if (dleft[c] == 0) tx_done[c] <= 1'b0;
        else               dleft[c]   <= dleft[c] - 1;
      end else if ((c == 0) ? dv0 : dv1) begin
        frame[c]     <= {1'b1, ((c == 0) ? byte0 : byte1), 1'b0};
        tx_active[c] <= 1'b1;
        cnt[c]       <= 0;
        ser[c]       <= 1'b0;
      end
    end
  end

  bit         rx_busy = 1'b0;
  int         rxn = 0;
  logic [7:0] rxb = '0;

  always @(negedge clk) begin
    if (dv0) q_dv0.push_back(byte0);
    if (dv1) q_dv1.push_back(byte1);
    if (dv0 && (tx_active[0] || tx_done[0])) viol++;
    if (dv1 && (tx_active[1] || tx_done[1])) viol++;
    if (done0) begin
      done_cnt0++;
      check("busy0_low_at_done", busy0, 0);
    end
    if (done1) begin
      done_cnt1++;
      check("busy1_low_at_done", busy1, 0);
    end
    if (!rx_busy) begin
      if (ser[0] == 1'b0) begin
        rx_busy = 1'b1;
        rxn = 0;
      end
    end else begin
      rxn++;
      if ((rxn % 4 == 2) && rxn >= 6 && rxn <= 34) rxb = {ser[0], rxb[7:1]};
      if (rxn == 38) begin
        q_rx0.push_back(rxb);
        rx_busy = 1'b0;
      end
    end
  end

  task automatic run_frame(input logic [255:0] dig, input bit mid_start, input string tag);
    logic [7:0] exp[$];
    int k;
    bit hit;
    for (int i = 0; i < 32; i++) exp.push_back(dig[255 - 8*i -: 8]);
    if (TAIL != 0) begin
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
    end
    q_dv0.delete();
    q_rx0.delete();
    done_cnt0 = 0;
    hit = 1'b0;
    @(negedge clk);
    digest0 = dig;
    start0  = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check({tag, "_busy_after_accept"}, busy0, 1);
    k = 0;
    while (done_cnt0 == 0 && k < 4000) begin
      @(negedge clk);
      k++;
      start0 = 1'b0;
      if (mid_start && !hit && q_dv0.size() == 3) begin
        digest0 = ~dig;
        start0  = 1'b1;
        hit     = 1'b1;
      end
    end
    check({tag, "_done_in_time"}, (k < 4000), 1);
    repeat (10) @(negedge clk);
    check({tag, "_dv_count"}, q_dv0.size(), exp.size());
    check({tag, "_rx_count"}, q_rx0.size(), exp.size());
    check({tag, "_done_count"}, done_cnt0, 1);
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_dv_byte%0d", tag, i), (i < q_dv0.size()) ? {24'h0, q_dv0[i]} : 32'hFFFF_FFFF, exp[i]);
      check($sformatf("%s_rx_byte%0d", tag, i), (i < q_rx0.size()) ? {24'h0, q_rx0[i]} : 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  initial begin
    int k;
    logic [7:0] exp1[$];

    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_dv", dv0, 0);
    check("rst_byte", byte0, 8'h00);
    rst = 1'b0;

    run_frame(DIG_PAT, 1'b0, "pattern");
    done_len = 2;
    run_frame(DIG_INC, 1'b0, "done_hold");
    done_len = 1;
    run_frame({16{16'hC33C}}, 1'b1, "mid_start");

    // Abort after byte 5 has been handed to the transmitter.
    q_dv0.delete();
    done_cnt0 = 0;
    @(negedge clk);
    digest0 = DIG_PAT;
    start0  = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (q_dv0.size() < 6 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_byte5", (k < 2000), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy0, 0);
    check("abort_dv", dv0, 0);
    check("abort_byte", byte0, 8'h00);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt0, 0);
    check("abort_dv_count", q_dv0.size(), 6);
    k = 0;
    while ((tx_active[0] || tx_done[0]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    run_frame(DIG_INC, 1'b0, "after_abort");

    // Single-byte instance.
    exp1.push_back(8'hA5);
    if (TAIL != 0) begin
      exp1.push_back(8'h0D);
      exp1.push_back(8'h0A);
    end
    q_dv1.delete();
    done_cnt1 = 0;
    @(negedge clk);
    digest1 = 8'hA5;
    start1  = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("nb1_busy", busy1, 1);
    k = 0;
    while (done_cnt1 == 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("nb1_done_in_time", (k < 1000), 1);
    repeat (10) @(negedge clk);
    check("nb1_dv_count", q_dv1.size(), exp1.size());
    check("nb1_done_count", done_cnt1, 1);
    for (int i = 0; i < exp1.size(); i++)
      check($sformatf("nb1_byte%0d", i), (i < q_dv1.size()) ? {24'h0, q_dv1[i]} : 32'hFFFF_FFFF, exp1[i]);

    check("no_dv_while_tx_busy", viol, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
